axi_slave_rd_burst: RTL and testbench

- AXI4 read-channel responder (slave end). Accepts one AR burst at a time and walks the per-beat byte addresses for FIXED, INCR and WRAP bursts.
- Issues one synchronous memory read per beat and returns R beats with RID, RRESP and RLAST.
- Sits between an AXI interconnect master port and a simple single-port SRAM or register-file read interface.

---
 rtl/axi_slave_rd_burst.sv | 187 ++++++++++++++++++
 tb/tb_axi_slave_rd_burst.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_rd_burst.sv
// AXI4 read-burst responder: one AR burst at a time, walking FIXED/INCR/WRAP beat addresses.
// One synchronous SRAM read per beat (two cycles per beat); SLVERR bursts skip memory and return zeros.
module axi_slave_rd_burst #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int IW  = 4,
   parameter int LEN = 8
) (
   input  logic           aclk,
   input  logic           aresetn,
   input  logic [IW-1:0]  s_axi_arid,
   input  logic [AW-1:0]  s_axi_araddr,
   input  logic [LEN-1:0] s_axi_arlen,
   input  logic [2:0]     s_axi_arsize,
   input  logic [1:0]     s_axi_arburst,
   input  logic           s_axi_arvalid,
   output logic           s_axi_arready,
   output logic [IW-1:0]  s_axi_rid,
   output logic [DW-1:0]  s_axi_rdata,
   output logic [1:0]     s_axi_rresp,
   output logic           s_axi_rlast,
   output logic           s_axi_rvalid,
   input  logic           s_axi_rready,
   output logic           mem_rd_en,
   output logic [AW-1:0]  mem_rd_addr,
   input  logic [DW-1:0]  mem_rd_data
);
   localparam logic [2:0] SZ_MAX = 3'($clog2(DW / 8));

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

   state_t         state_q, state_d;
   logic           arready_q, arready_d;
   logic [IW-1:0]  id_q, id_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [LEN-1:0] len_q, len_d;
   logic [2:0]     size_q, size_d;
   logic [1:0]     burst_q, burst_d;
   logic           err_q, err_d;
   logic [LEN:0]   cnt_q, cnt_d;
   logic           pend_q, pend_d;
   logic           pend_last_q, pend_last_d;
   logic           rvalid_q, rvalid_d;
   logic [DW-1:0]  rdata_q, rdata_d;
   logic [1:0]     rresp_q, rresp_d;
   logic           rlast_q, rlast_d;
   logic [IW-1:0]  rid_q, rid_d;

   logic           issue, ar_hs, r_hs, beat_last, wrap_len_ok;
   logic [AW-1:0]  step, wmask, addr_inc, addr_next;

   assign ar_hs     = s_axi_arvalid && arready_q;
   assign r_hs      = rvalid_q && s_axi_rready;
   assign issue     = (state_q == ACTIVE) && !pend_q && (!rvalid_q || s_axi_rready);
   assign beat_last = (cnt_q == {1'b0, len_q});

   assign wrap_len_ok = (s_axi_arlen == LEN'(1)) || (s_axi_arlen == LEN'(3)) ||
                        (s_axi_arlen == LEN'(7)) || (s_axi_arlen == LEN'(15));

   // WRAP window spans (len+1) beats; INCR realigns after a possibly unaligned first beat.
   assign step     = AW'(1) << size_q;
   assign wmask    = step * (AW'(len_q) + AW'(1)) - AW'(1);
   assign addr_inc = addr_q + step;

   always_comb begin
      addr_next = addr_inc & ~(step - AW'(1));
      case (burst_q)
         2'b00:   addr_next = addr_q;
         2'b10:   addr_next = (addr_q & ~wmask) | (addr_inc & wmask);
         default: addr_next = addr_inc & ~(step - AW'(1));
      endcase
   end

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      addr_d      = addr_q;
      len_d       = len_q;
      size_d      = size_q;
      burst_d     = burst_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      pend_last_d = pend_last_q;
      rvalid_d    = rvalid_q && !s_axi_rready;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      rlast_d     = rlast_q;
      rid_d       = rid_q;

      // Memory data arrives the cycle after the strobe; the R register is free by construction.
      if (pend_q) begin
         rdata_d  = mem_rd_data;
         rresp_d  = 2'b00;
         rid_d    = id_q;
         rlast_d  = pend_last_q;
         rvalid_d = 1'b1;
         pend_d   = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (ar_hs) begin
               id_d    = s_axi_arid;
               addr_d  = s_axi_araddr;
               len_d   = s_axi_arlen;
               size_d  = s_axi_arsize;
               burst_d = s_axi_arburst;
               err_d   = (s_axi_arsize > SZ_MAX) || ((s_axi_arburst == 2'b10) && !wrap_len_ok);
               cnt_d   = '0;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (issue) begin
               cnt_d  = cnt_q + 1'b1;
               addr_d = addr_next;
               if (err_q) begin
                  rdata_d  = '0;
                  rresp_d  = 2'b10;
                  rid_d    = id_q;
                  rlast_d  = beat_last;
                  rvalid_d = 1'b1;
               end else begin
                  pend_d      = 1'b1;
                  pend_last_d = beat_last;
               end
               if (beat_last) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (r_hs && rlast_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      arready_d = (state_d == IDLE);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         arready_q   <= 1'b0;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         rresp_q     <= '0;
         rlast_q     <= 1'b0;
         rid_q       <= '0;
      end else begin
         state_q     <= state_d;
         arready_q   <= arready_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         size_q      <= size_d;
         burst_q     <= burst_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         rresp_q     <= rresp_d;
         rlast_q     <= rlast_d;
         rid_q       <= rid_d;
      end
   end

   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rlast   = rlast_q;
   assign s_axi_rid     = rid_q;
   assign mem_rd_en     = issue && !err_q;
   assign mem_rd_addr   = addr_q;

endmodule

// File: tb/tb_axi_slave_rd_burst.sv
// Bench for axi_slave_rd_burst: directed burst table, hand-written reset sequence, random bursts vs a reference model.
`timescale 1ns/1ps
module tb_axi_slave_rd_burst;
   localparam int AW = 32, DW = 32, IW = 4, LEN = 8;

   logic           aclk = 1'b0;
   logic           aresetn = 1'b0;
   logic [IW-1:0]  s_axi_arid = '0;
   logic [AW-1:0]  s_axi_araddr = '0;
   logic [LEN-1:0] s_axi_arlen = '0;
   logic [2:0]     s_axi_arsize = '0;
   logic [1:0]     s_axi_arburst = '0;
   logic           s_axi_arvalid = 1'b0;
   logic           s_axi_arready;
   logic [IW-1:0]  s_axi_rid;
   logic [DW-1:0]  s_axi_rdata;
   logic [1:0]     s_axi_rresp;
   logic           s_axi_rlast;
   logic           s_axi_rvalid;
   logic           s_axi_rready = 1'b0;
   logic           mem_rd_en;
   logic [AW-1:0]  mem_rd_addr;
   logic [DW-1:0]  mem_rd_data;

   int checks = 0;
   int errors = 0;
   logic [31:0] obs_addr[$];
   logic [1:0]  first_resp;

   axi_slave_rd_burst #(.AW(AW), .DW(DW), .IW(IW), .LEN(LEN)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
   );

   always #5 aclk = ~aclk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Data is valid only the cycle after a strobe; garbage otherwise.
   always @(posedge aclk) mem_rd_data <= mem_rd_en ? memf(mem_rd_addr) : $urandom;

   function automatic logic [31:0] model_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst, input int k);
      logic [31:0] sb, tot, base;
      sb = 32'd1 << size;
      case (burst)
         2'b00: return addr;
         2'b10: begin
            tot  = sb * (32'(len) + 32'd1);
            base = addr & ~(tot - 32'd1);
            return base + ((addr - base + 32'(k) * sb) % tot);
         end
         default: return (k == 0) ? addr : (addr & ~(sb - 32'd1)) + 32'(k) * sb;
      endcase
   endfunction

   function automatic bit model_err(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
      return (size > 3'd2) || (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output bit ok);
      ok = 1'b0;
      @(posedge aclk); #1;
      s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
      s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge aclk);
         if (s_axi_arready) ok = 1'b1;
         @(posedge aclk); #1;
      end
      s_axi_arvalid = 1'b0;
      chk("ar_accept", 64'(ok), 64'd1);
   endtask

   // mode 0: rready always high, 1: random rready, 2: hold beat 2 for 5 cycles.
   task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode);
      bit ok, err, done, prev_hold;
      int cyc, beats, reads, stall;
      logic [31:0] expq[$];
      logic [31:0] pdata;
      logic [1:0]  presp;
      logic        plast;
      logic [3:0]  pid;
      err = model_err(size, burst, len);
      for (int k = 0; k <= int'(len); k++) expq.push_back(model_addr(addr, len, size, burst, k));
      obs_addr.delete();
      first_resp = 2'b11;
      done = 0; cyc = 0; beats = 0; reads = 0; stall = 0; prev_hold = 0;
      pdata = '0; presp = '0; plast = 1'b0; pid = '0;
      send_ar(id, addr, len, size, burst, ok);
      while (ok && !done && cyc < 3000) begin
         case (mode)
            0: s_axi_rready = 1'b1;
            1: s_axi_rready = ($urandom_range(0, 3) != 0);
            default: begin
               if (s_axi_rvalid && beats == 1 && stall < 5) begin
                  s_axi_rready = 1'b0;
                  stall++;
               end else s_axi_rready = 1'b1;
            end
         endcase
         @(negedge aclk);
         cyc++;
         if (mem_rd_en) begin
            chk("issue_while_held", 64'(!s_axi_rvalid || s_axi_rready), 64'd1);
            if (!err && reads <= int'(len)) chk("rd_addr", 64'(mem_rd_addr), 64'(expq[reads]));
            obs_addr.push_back(mem_rd_addr);
            reads++;
         end
         if (prev_hold) begin
            chk("hold_rvalid", 64'(s_axi_rvalid), 64'd1);
            chk("hold_rdata", 64'(s_axi_rdata), 64'(pdata));
            chk("hold_rresp", 64'(s_axi_rresp), 64'(presp));
            chk("hold_rlast", 64'(s_axi_rlast), 64'(plast));
            chk("hold_rid", 64'(s_axi_rid), 64'(pid));
         end
         if (s_axi_rvalid && s_axi_rready) begin
            if (beats == 0) first_resp = s_axi_rresp;
            chk("rdata", 64'(s_axi_rdata), err ? 64'd0 : 64'(memf(expq[beats])));
            chk("rresp", 64'(s_axi_rresp), err ? 64'd2 : 64'd0);
            chk("rid", 64'(s_axi_rid), 64'(id));
            chk("rlast", 64'(s_axi_rlast), 64'(beats == int'(len)));
            if (beats == int'(len)) done = 1;
            beats++;
         end
         prev_hold = s_axi_rvalid && !s_axi_rready;
         pdata = s_axi_rdata; presp = s_axi_rresp; plast = s_axi_rlast; pid = s_axi_rid;
         @(posedge aclk); #1;
      end
      s_axi_rready = 1'b0;
      chk("burst_done", 64'(done), 64'd1);
      chk("read_count", 64'(reads), err ? 64'd0 : 64'(int'(len) + 1));
      if (mode == 0) chk("latency", 64'(cyc), err ? 64'(int'(len) + 2) : 64'(2 * int'(len) + 3));
      if (mode == 2) chk("stall_cycles", 64'(stall), 64'd5);
      @(negedge aclk);
      chk("arready_after", 64'(s_axi_arready), 64'd1);
   endtask

   typedef struct {
      logic [3:0]        id;
      logic [31:0]       addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
      int                mode;
      bit                exp_err;
      logic [3:0][31:0]  exp_a;
   } vec_t;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[12];
      bit   ok;
      int   beats;
      logic [7:0] rlen;
      logic [2:0] rsize;
      logic [1:0] rburst;

      vecs[0]  = '{4'h5, 32'h100, 8'd3, 3'd2, 2'b01, 0, 1'b0, {32'h10C, 32'h108, 32'h104, 32'h100}};
      vecs[1]  = '{4'h1, 32'h103, 8'd1, 3'd2, 2'b01, 0, 1'b0, {32'h0, 32'h0, 32'h104, 32'h103}};
      vecs[2]  = '{4'h2, 32'h108, 8'd3, 3'd2, 2'b10, 0, 1'b0, {32'h104, 32'h100, 32'h10C, 32'h108}};
      vecs[3]  = '{4'h3, 32'h40, 8'd2, 3'd2, 2'b00, 0, 1'b0, {32'h0, 32'h40, 32'h40, 32'h40}};
      vecs[4]  = '{4'h6, 32'h200, 8'd3, 3'd2, 2'b01, 2, 1'b0, {32'h20C, 32'h208, 32'h204, 32'h200}};
      vecs[5]  = '{4'h7, 32'h80, 8'd1, 3'd3, 2'b01, 0, 1'b1, {32'h0, 32'h0, 32'h0, 32'h0}};
      vecs[6]  = '{4'h8, 32'h100, 8'd2, 3'd2, 2'b10, 0, 1'b1, {32'h0, 32'h0, 32'h0, 32'h0}};
      vecs[7]  = '{4'h9, 32'h0, 8'd0, 3'd0, 2'b01, 0, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0}};
      vecs[8]  = '{4'hA, 32'h1000, 8'd255, 3'd2, 2'b01, 0, 1'b0, {32'h100C, 32'h1008, 32'h1004, 32'h1000}};
      vecs[9]  = '{4'hB, 32'hFFFF_FFFC, 8'd2, 3'd2, 2'b01, 0, 1'b0, {32'h0, 32'h4, 32'h0, 32'hFFFF_FFFC}};
      vecs[10] = '{4'hC, 32'h10, 8'd1, 3'd1, 2'b11, 0, 1'b0, {32'h0, 32'h0, 32'h12, 32'h10}};
      vecs[11] = '{4'hD, 32'h36, 8'd7, 3'd1, 2'b10, 1, 1'b0, {32'h3C, 32'h3A, 32'h38, 32'h36}};

      // Reset state and arready release timing.
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_arready", 64'(s_axi_arready), 64'd0);
      chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
      chk("rst_rlast", 64'(s_axi_rlast), 64'd0);
      chk("rst_rresp", 64'(s_axi_rresp), 64'd0);
      chk("rst_rid", 64'(s_axi_rid), 64'd0);
      chk("rst_rdata", 64'(s_axi_rdata), 64'd0);
      chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
      chk("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(negedge aclk);
      chk("arready_before_edge", 64'(s_axi_arready), 64'd0);
      @(negedge aclk);
      chk("arready_after_release", 64'(s_axi_arready), 64'd1);

      for (int i = 0; i < 12; i++) begin
         run_burst(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].mode);
         if (!vecs[i].exp_err)
            for (int k = 0; k < 4 && k <= int'(vecs[i].len); k++)
               chk("tbl_addr", 64'(obs_addr.size() > k ? obs_addr[k] : 32'hDEAD_BEEF), 64'(vecs[i].exp_a[k]));
         chk("tbl_resp", 64'(first_resp), vecs[i].exp_err ? 64'd2 : 64'd0);
      end

      // Reset while beat 2 of a len=7 burst is held valid.
      send_ar(4'h4, 32'h300, 8'd7, 3'd2, 2'b01, ok);
      beats = 0;
      for (int n = 0; n < 40; n++) begin
         s_axi_rready = (beats == 0);
         @(negedge aclk);
         if (s_axi_rvalid && s_axi_rready) beats++;
         else if (s_axi_rvalid && beats == 1) break;
         @(posedge aclk); #1;
      end
      chk("beat2_reached", 64'(beats == 1 && s_axi_rvalid), 64'd1);
      @(posedge aclk); #1;
      aresetn = 1'b0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(negedge aclk);
      chk("midrst_rvalid", 64'(s_axi_rvalid), 64'd0);
      chk("midrst_mem_rd_en", 64'(mem_rd_en), 64'd0);
      chk("midrst_arready", 64'(s_axi_arready), 64'd0);
      @(negedge aclk);
      chk("midrst_arready_release", 64'(s_axi_arready), 64'd1);
      chk("midrst_discard", 64'(s_axi_rvalid), 64'd0);
      run_burst(4'hE, 32'h400, 8'd3, 3'd2, 2'b01, 0);

      // Random bursts against the reference model.
      for (int i = 0; i < 30; i++) begin
         rlen   = 8'($urandom_range(0, 20));
         rsize  = 3'($urandom_range(0, 3));
         rburst = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) rlen = 8'(($urandom_range(0, 3) * 2 + 1) % 16);
         run_burst(4'($urandom), $urandom, rlen, rsize, rburst, int'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
